// File: rtl/user_gpio_sequencer.sv
// ----------------------------------------------------------------------------
// user_gpio_sequencer
//
// Wishbone-programmable pattern scheduler for a 16-pad window of mprj_io.
// Firmware loads a table of (pattern, dwell) pairs, sets a prescaler and the
// pad output enables, then starts a run. Each table entry drives the window
// for 1 + (D+1)(P+1) cycles. The run either stops after the last entry
// (raising done / irq) or loops back to entry 0 until stopped.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i        Wishbone classic controls
//   wbs_sel_i[3:0]              byte enables for writes
//   wbs_adr_i/dat_i[31:0]       address and write data
//   wbs_ack_o                   one-cycle acknowledge
//   wbs_dat_o[31:0]             read data, valid with ack
//   io_in[37:0]                 pad inputs (window readable via STATUS)
//   io_out[37:0]                pad outputs, window carries the current pattern
//   io_oeb[37:0]                active-low pad enables, window = ~OE
//   user_irq[2:0]               bit 0 = done & irq_en
//
// Register map (byte offsets from BASE):
//   0x00 CTRL      [0] start (pulse) [1] stop (pulse) [2] loop [3] irq_en
//                  [7:4] last index
//   0x04 STATUS    [0] busy [1] done (write 1 clears) [7:4] index
//                  [31:16] io_in window
//   0x08 PRESCALE  [15:0]
//   0x0C OE        [15:0]
//   0x40+4i        PATTERN[i]
//   0x80+4i        DWELL[i]
// ----------------------------------------------------------------------------
module user_gpio_sequencer #(
    parameter logic [31:0] BASE     = 32'h3000_0000,
    parameter int          FIRST_IO = 22,
    parameter int          DEPTH    = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [37:0] io_in,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb,
    output logic [2:0]  user_irq
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DWELL
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [15:0]   out_q, out_d;
    logic [15:0]   dwell_cnt_q, dwell_cnt_d;
    logic [15:0]   presc_cnt_q, presc_cnt_d;
    logic [15:0]   presc_q, presc_d;
    logic [15:0]   oe_q, oe_d;
    logic          loop_q, loop_d;
    logic          irq_en_q, irq_en_d;
    logic [3:0]    last_q, last_d;
    logic          done_q, done_d;
    logic          ack_q, ack_d;
    logic [31:0]   dat_q, dat_d;
    logic [15:0]   pattern_q [DEPTH];
    logic [15:0]   pattern_d [DEPTH];
    logic [15:0]   dwell_q [DEPTH];
    logic [15:0]   dwell_d [DEPTH];

    logic          wb_req;
    logic          wb_wr;
    logic          wb_rd;
    logic [5:0]    word;
    logic          tbl_hit;
    logic [IW-1:0] tbl_idx;
    logic [IW-1:0] last_idx;
    logic [3:0]    idx_ext;
    logic          busy;
    logic          start_pls;
    logic          stop_pls;
    logic          done_clr;
    logic          done_set;
    logic          start_ok;
    logic          unused_bits;

    // A new request is only taken while ack is low, which both produces the
    // single-cycle ack and guarantees a low cycle between transactions.
    assign wb_req   = wbs_cyc_i && wbs_stb_i && !ack_q &&
                      (wbs_adr_i[31:8] == BASE[31:8]);
    assign wb_wr    = wb_req && wbs_we_i;
    assign wb_rd    = wb_req && !wbs_we_i;
    assign word     = wbs_adr_i[7:2];
    assign tbl_hit  = ({2'b00, word[3:0]} < 6'(DEPTH));
    assign tbl_idx  = word[IW-1:0];
    // Truncation implements the modulo-DEPTH wrap of the last index.
    assign last_idx = last_q[IW-1:0];
    assign idx_ext  = 4'(idx_q);
    assign busy     = (state_q != ST_IDLE);

    assign unused_bits = ^{wbs_dat_i[31:16], wbs_sel_i[3:2], wbs_adr_i[1:0], io_in};

    function automatic logic [15:0] merge16(input logic [15:0] old_v,
                                            input logic [15:0] new_v,
                                            input logic [1:0]  sel);
        logic [15:0] r;
        r = old_v;
        if (sel[0]) r[7:0]  = new_v[7:0];
        if (sel[1]) r[15:8] = new_v[15:8];
        return r;
    endfunction

    // Bus side: register writes, command pulses and registered read data.
    always_comb begin
        loop_d    = loop_q;
        irq_en_d  = irq_en_q;
        last_d    = last_q;
        presc_d   = presc_q;
        oe_d      = oe_q;
        pattern_d = pattern_q;
        dwell_d   = dwell_q;
        start_pls = 1'b0;
        stop_pls  = 1'b0;
        done_clr  = 1'b0;
        ack_d     = wb_req;
        dat_d     = 32'h0;

        if (wb_wr) begin
            case (word)
                6'h00: begin
                    if (wbs_sel_i[0]) begin
                        start_pls = wbs_dat_i[0];
                        stop_pls  = wbs_dat_i[1];
                        loop_d    = wbs_dat_i[2];
                        irq_en_d  = wbs_dat_i[3];
                        last_d    = wbs_dat_i[7:4];
                    end
                end
                6'h01: done_clr = wbs_sel_i[0] && wbs_dat_i[1];
                6'h02: presc_d  = merge16(presc_q, wbs_dat_i[15:0], wbs_sel_i[1:0]);
                6'h03: oe_d     = merge16(oe_q, wbs_dat_i[15:0], wbs_sel_i[1:0]);
                default: begin
                    if (word[5:4] == 2'b01 && tbl_hit) begin
                        pattern_d[tbl_idx] = merge16(pattern_q[tbl_idx],
                                                     wbs_dat_i[15:0], wbs_sel_i[1:0]);
                    end else if (word[5:4] == 2'b10 && tbl_hit) begin
                        dwell_d[tbl_idx] = merge16(dwell_q[tbl_idx],
                                                   wbs_dat_i[15:0], wbs_sel_i[1:0]);
                    end
                end
            endcase
        end

        if (wb_rd) begin
            case (word)
                6'h00: dat_d = {24'h0, last_q, irq_en_q, loop_q, 2'b00};
                6'h01: dat_d = {io_in[FIRST_IO +: 16], 8'h00, idx_ext, 2'b00, done_q, busy};
                6'h02: dat_d = {16'h0, presc_q};
                6'h03: dat_d = {16'h0, oe_q};
                default: begin
                    if (word[5:4] == 2'b01 && tbl_hit) begin
                        dat_d = {16'h0, pattern_q[tbl_idx]};
                    end else if (word[5:4] == 2'b10 && tbl_hit) begin
                        dat_d = {16'h0, dwell_q[tbl_idx]};
                    end
                end
            endcase
        end
    end

    // Sequencer: table entries and P are sampled live at LOAD / reload time,
    // so firmware may rewrite them mid-run. Stop has priority over everything
    // and leaves out_q untouched.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_d       = out_q;
        dwell_cnt_d = dwell_cnt_q;
        presc_cnt_d = presc_cnt_q;
        done_set    = 1'b0;
        start_ok    = (state_q == ST_IDLE) && start_pls && !stop_pls;

        if (stop_pls && busy) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    out_d       = pattern_q[idx_q];
                    dwell_cnt_d = dwell_q[idx_q];
                    presc_cnt_d = presc_q;
                    state_d     = ST_DWELL;
                end
                ST_DWELL: begin
                    if (presc_cnt_q != 16'h0) begin
                        presc_cnt_d = presc_cnt_q - 16'd1;
                    end else begin
                        presc_cnt_d = presc_q;
                        if (dwell_cnt_q != 16'h0) begin
                            dwell_cnt_d = dwell_cnt_q - 16'd1;
                        end else if (idx_q != last_idx) begin
                            idx_d   = idx_q + IW'(1);
                            state_d = ST_LOAD;
                        end else if (loop_q) begin
                            idx_d   = '0;
                            state_d = ST_LOAD;
                        end else begin
                            done_set = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Completion wins over a simultaneous write-1-to-clear.
        if (done_set) begin
            done_d = 1'b1;
        end else if (start_ok || done_clr) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            out_q       <= '0;
            dwell_cnt_q <= '0;
            presc_cnt_q <= '0;
            presc_q     <= '0;
            oe_q        <= '0;
            loop_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            last_q      <= '0;
            done_q      <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pattern_q[i] <= '0;
                dwell_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            dwell_cnt_q <= dwell_cnt_d;
            presc_cnt_q <= presc_cnt_d;
            presc_q     <= presc_d;
            oe_q        <= oe_d;
            loop_q      <= loop_d;
            irq_en_q    <= irq_en_d;
            last_q      <= last_d;
            done_q      <= done_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            pattern_q   <= pattern_d;
            dwell_q     <= dwell_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign user_irq  = {2'b00, done_q & irq_en_q};

    always_comb begin
        io_out                  = '0;
        io_out[FIRST_IO +: 16]  = out_q;
        io_oeb                  = '1;
        io_oeb[FIRST_IO +: 16]  = ~oe_q;
    end

endmodule

// File: tb/tb_user_gpio_sequencer.sv
// ----------------------------------------------------------------------------
// tb_user_gpio_sequencer
//
// Directed bench for user_gpio_sequencer. Wishbone reads push their expected
// data into a scoreboard queue; an independent monitor pops and compares on
// every read acknowledge. Pad waveforms are checked cycle by cycle against
// hand-computed step timing (1 + (D+1)(P+1) cycles per entry).
// ----------------------------------------------------------------------------
module tb_user_gpio_sequencer;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [37:0] io_in;
    logic [37:0] io_out;
    logic [37:0] io_oeb;
    logic [2:0]  user_irq;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
        logic [31:0] mask;
    } rd_exp_t;

    rd_exp_t exp_q[$];

    int busy_mis;
    int busy_irq_mis;

    always #5 clk = ~clk;

    user_gpio_sequencer dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (wb_rst_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .user_irq  (user_irq)
    );

    // Read monitor: every read ack is matched against the oldest expectation.
    always @(negedge clk) begin : monitor
        rd_exp_t e;
        if (wbs_ack_o && !wbs_we_i) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL unexpected_read: got 0x%08h, no read expected", wbs_dat_o);
            end else begin
                e = exp_q.pop_front();
                if ((wbs_dat_o & e.mask) !== (e.exp & e.mask)) begin
                    n_fail++;
                    $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (mask 0x%08h)",
                             e.name, wbs_dat_o, e.exp, e.mask);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One Wishbone transfer; inputs change on the falling edge and are
    // released on the falling edge after the ack is seen.
    task automatic wbXfer(input logic we, input logic [7:0] off,
                          input logic [31:0] dat, input logic [3:0] sel);
        logic got;
        @(negedge clk);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = BASE | {24'h0, off};
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            got = wbs_ack_o;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL ack_timeout: got no ack expected ack at offset 0x%02h", off);
        end
        @(negedge clk);
        #1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
    endtask

    task automatic applyStimulus(input logic [7:0] off, input logic [31:0] dat);
        wbXfer(1'b1, off, dat, 4'hF);
    endtask

    task automatic wbRead(input string name, input logic [7:0] off,
                          input logic [31:0] exp, input logic [31:0] mask);
        rd_exp_t e;
        e.name = name;
        e.exp  = exp;
        e.mask = mask;
        exp_q.push_back(e);
        wbXfer(1'b0, off, 32'h0, 4'hF);
    endtask

    // Expected io_out[22] in loop mode, sampled at the k-th falling edge
    // after the start ack edge; 7-cycle steps alternating 1, 0.
    function automatic logic waveAt(input int k);
        return (((k - 2) / 7) % 2) == 0;
    endfunction

    initial begin
        logic [37:0] exp_oeb;
        logic        pad_s [2:16];
        logic        irq_s [2:16];
        int          hi_cnt;
        int          mis;
        logic        hold_exp;
        logic [15:0] exp_win;

        wb_rst_i  = 1'b1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
        wbs_adr_i = 32'h0;
        wbs_dat_i = 32'h0;
        io_in     = '0;
        repeat (3) @(negedge clk);
        wb_rst_i = 1'b0;
        @(negedge clk);

        // Reset state
        checkOutput("reset_io_out", 64'(io_out), 64'h0);
        checkOutput("reset_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
        checkOutput("reset_irq", 64'(user_irq), 64'h0);
        checkOutput("reset_ack", 64'(wbs_ack_o), 64'h0);
        checkOutput("reset_dat", 64'(wbs_dat_o), 64'h0);
        wbRead("status_reset", 8'h04, 32'h0, 32'hFFFF_FFFF);
        io_in[37:22] = 16'hBEEF;
        wbRead("status_io_in", 8'h04, 32'hBEEF_0000, 32'hFFFF_FFFF);
        io_in = '0;

        // Basic run: P=1, D=2, two entries
        applyStimulus(8'h08, 32'h1);
        applyStimulus(8'h0C, 32'hFFFF);
        applyStimulus(8'h40, 32'h0001);
        applyStimulus(8'h44, 32'h0000);
        applyStimulus(8'h80, 32'h2);
        applyStimulus(8'h84, 32'h2);
        exp_oeb = '1;
        exp_oeb[37:22] = '0;
        checkOutput("oe_full_window", 64'(io_oeb), 64'(exp_oeb));
        applyStimulus(8'h00, 32'h19);
        hi_cnt = 0;
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk);
            pad_s[k] = io_out[22];
            irq_s[k] = user_irq[0];
            if (io_out[22]) hi_cnt++;
        end
        checkOutput("basic_high_cycles", 64'(hi_cnt), 64'd7);
        checkOutput("basic_first_high", 64'(pad_s[2]), 64'd1);
        checkOutput("basic_last_high", 64'(pad_s[8]), 64'd1);
        checkOutput("basic_first_low", 64'(pad_s[9]), 64'd0);
        checkOutput("basic_irq_before_done", 64'(irq_s[14]), 64'd0);
        checkOutput("basic_irq_at_done", 64'(irq_s[15]), 64'd1);
        wbRead("status_done", 8'h04, 32'h0000_0012, 32'hFFFF_FFFF);
        wbRead("ctrl_readback", 8'h00, 32'h0000_0018, 32'hFFFF_FFFF);
        wbRead("pattern0_readback", 8'h40, 32'h0000_0001, 32'hFFFF_FFFF);
        wbRead("dwell1_readback", 8'h84, 32'h0000_0002, 32'hFFFF_FFFF);

        // Done write-1-to-clear
        applyStimulus(8'h04, 32'h2);
        wbRead("status_w1c", 8'h04, 32'h0000_0010, 32'hFFFF_FFFF);
        checkOutput("irq_after_w1c", 64'(user_irq), 64'h0);

        // Loop mode for 10 full periods, then stop
        applyStimulus(8'h00, 32'h1D);
        mis = 0;
        for (int k = 2; k <= 141; k++) begin
            @(negedge clk);
            if (io_out[22] !== waveAt(k)) mis++;
        end
        checkOutput("loop_wave_mismatches", 64'(mis), 64'd0);
        hold_exp = waveAt(142);
        applyStimulus(8'h00, 32'h1E);
        mis = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (io_out[22] !== hold_exp) mis++;
        end
        checkOutput("stop_pad_hold", 64'(mis), 64'd0);
        wbRead("status_after_stop", 8'h04, 32'h0, 32'h0000_0003);
        checkOutput("irq_after_stop", 64'(user_irq), 64'h0);

        // Start and stop in the same write: nothing starts
        applyStimulus(8'h00, 32'h1B);
        wbRead("status_start_stop", 8'h04, 32'h0, 32'h0000_0001);

        // Start while busy must not disturb the sequence
        applyStimulus(8'h08, 32'h0);
        applyStimulus(8'h40, 32'h0011);
        applyStimulus(8'h44, 32'h0022);
        applyStimulus(8'h48, 32'h0033);
        applyStimulus(8'h80, 32'h3);
        applyStimulus(8'h84, 32'h3);
        applyStimulus(8'h88, 32'h3);
        applyStimulus(8'h00, 32'h29);
        busy_mis = 0;
        busy_irq_mis = 0;
        fork
            begin
                for (int k = 2; k <= 20; k++) begin
                    @(negedge clk);
                    case ((k - 2) / 5)
                        0: exp_win = 16'h0011;
                        1: exp_win = 16'h0022;
                        default: exp_win = 16'h0033;
                    endcase
                    if (io_out[37:22] !== exp_win) busy_mis++;
                    if (user_irq[0] !== (k >= 16)) busy_irq_mis++;
                end
            end
            begin
                repeat (3) @(negedge clk);
                applyStimulus(8'h00, 32'h29);
            end
        join
        checkOutput("busy_start_sequence", 64'(busy_mis), 64'd0);
        checkOutput("busy_start_irq_timing", 64'(busy_irq_mis), 64'd0);
        wbRead("status_three_steps", 8'h04, 32'h0000_0022, 32'hFFFF_FFFF);

        // Minimum step: P=0, D=0, last=0
        applyStimulus(8'h80, 32'h0);
        applyStimulus(8'h40, 32'hA5A5);
        applyStimulus(8'h00, 32'h09);
        @(negedge clk);
        checkOutput("min_step_window", 64'(io_out[37:22]), 64'hA5A5);
        checkOutput("min_step_irq_low", 64'(user_irq[0]), 64'd0);
        @(negedge clk);
        checkOutput("min_step_irq_high", 64'(user_irq[0]), 64'd1);
        checkOutput("min_step_io_out", 64'(io_out), 64'(38'hA5A5) << 22);
        wbRead("status_min_step", 8'h04, 32'h0000_0002, 32'hFFFF_FFFF);

        // OE masking
        applyStimulus(8'h0C, 32'h00FF);
        exp_oeb = '1;
        exp_oeb[29:22] = '0;
        checkOutput("oe_masking", 64'(io_oeb), 64'(exp_oeb));

        // Unmapped read with cycle held: exactly one ack cycle
        exp_q.push_back('{"unmapped_read", 32'h0, 32'hFFFF_FFFF});
        @(negedge clk);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_adr_i = BASE | 32'h10;
        @(negedge clk);
        checkOutput("unmapped_ack_high", 64'(wbs_ack_o), 64'd1);
        @(negedge clk);
        checkOutput("unmapped_ack_one_cycle", 64'(wbs_ack_o), 64'd0);
        #1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_sel_i = 4'h0;

        // Byte-select write to PRESCALE
        applyStimulus(8'h08, 32'hFFFF);
        wbXfer(1'b1, 8'h08, 32'h1234, 4'b0001);
        wbRead("prescale_byte_write", 8'h08, 32'h0000_FF34, 32'hFFFF_FFFF);

        // Reset in the middle of a long dwell
        applyStimulus(8'h08, 32'h0);
        applyStimulus(8'h0C, 32'hFFFF);
        applyStimulus(8'h40, 32'h5555);
        applyStimulus(8'h80, 32'd100);
        applyStimulus(8'h00, 32'h09);
        repeat (5) @(negedge clk);
        checkOutput("pre_reset_window", 64'(io_out[37:22]), 64'h5555);
        wb_rst_i = 1'b1;
        @(negedge clk);
        wb_rst_i = 1'b0;
        checkOutput("midrun_reset_io_out", 64'(io_out), 64'h0);
        checkOutput("midrun_reset_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
        checkOutput("midrun_reset_irq", 64'(user_irq), 64'h0);
        checkOutput("midrun_reset_ack", 64'(wbs_ack_o), 64'h0);
        applyStimulus(8'h00, 32'h01);
        repeat (3) @(negedge clk);
        checkOutput("post_reset_io_out", 64'(io_out), 64'h0);
        wbRead("post_reset_status", 8'h04, 32'h0000_0002, 32'hFFFF_FFFF);
        wbRead("post_reset_pattern0", 8'h40, 32'h0, 32'hFFFF_FFFF);

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
